// File: rtl/dot8_acc_pkg.sv
// dot8_acc_pkg: shared tag type, FP zero constant and slot width helper
package dot8_acc_pkg;
  localparam int ID_W = 8;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  typedef struct packed {
    logic busy;
    logic last;
    logic [ID_W-1:0] id;
  } tag_t;
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dot8_acc_fifo.sv
// dot8_acc_fifo: show-ahead synchronous FIFO with occupancy count
module dot8_acc_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = i_push & (r_cnt != (AW+1)'(DEPTH));
  assign w_pop = i_pop & (r_cnt != '0);
  assign o_data = r_mem[r_rp];
  assign o_count = r_cnt;
  // storage is not reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/dot8_acc_sched.sv
// dot8_acc_sched: interleaved accumulation scheduler around the dot8 FP pipeline
module dot8_acc_sched
  import dot8_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VECTOR_LENGTH = 8,
  parameter int DOT_LATENCY = 12,
  parameter int ID_WIDTH = ID_W,
  parameter int OUT_DEPTH = 16,
  localparam int VW = DATA_WIDTH * VECTOR_LENGTH,
  localparam int SW = slot_w(DOT_LATENCY),
  localparam int CW = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic [VW-1:0]         in_a,
  input  logic [VW-1:0]         in_b,
  output logic [SW-1:0]         slot_id,
  output logic                  slot_cont,
  output logic                  dot_ena,
  output logic [VW-1:0]         dot_a,
  output logic [VW-1:0]         dot_b,
  output logic [DATA_WIDTH-1:0] dot_acc,
  input  logic [DATA_WIDTH-1:0] dot_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic                  busy,
  output logic                  err
);
  tag_t r_tag [DOT_LATENCY];
  tag_t w_head, w_issue;
  logic r_ena, r_err;
  logic [SW-1:0] r_slot;
  logic [CW-1:0] r_cred, w_cnt;
  logic w_acc, w_recirc, w_push, w_pop, w_dec, w_any;
  assign w_head = r_tag[DOT_LATENCY-1];
  assign slot_cont = w_head.busy & ~w_head.last;
  assign w_acc = in_valid & (in_first == ~slot_cont) & (~in_last | (r_cred != '0)) & r_ena;
  assign w_recirc = ~w_acc & slot_cont;
  assign w_dec = w_acc & in_last;
  assign w_push = w_head.busy & w_head.last;
  assign w_pop = out_valid & out_ready;
  assign in_ready = w_acc;
  assign dot_ena = r_ena;
  assign slot_id = r_slot;
  assign err = r_err;
  assign dot_a = w_acc ? in_a : '0;
  assign dot_b = w_acc ? in_b : '0;
  assign dot_acc = (w_acc & ~in_first) | w_recirc ? dot_result : DATA_WIDTH'(FP_ZERO);
  assign w_issue = w_acc ? tag_t'{busy: 1'b1, last: in_last, id: in_id} : (w_recirc ? w_head : tag_t'('0));
  assign out_valid = w_cnt != '0;
  assign busy = w_any | out_valid;
  // any occupied slot anywhere in the delay line keeps the block busy
  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < DOT_LATENCY; i++) w_any = w_any | r_tag[i].busy;
  end
  // tag delay line tracks which element each pipeline stage belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DOT_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < DOT_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end
  // enable, slot counter, credits and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena <= 1'b0;
      r_slot <= '0;
      r_cred <= CW'(OUT_DEPTH);
      r_err <= 1'b0;
    end else begin
      r_ena <= 1'b1;
      r_slot <= r_ena ? ((r_slot == SW'(DOT_LATENCY-1)) ? '0 : r_slot + 1'b1) : r_slot;
      r_cred <= r_cred - CW'(w_dec) + CW'(w_pop);
      r_err <= r_err | (in_valid & (in_first == slot_cont));
    end
  end
  dot8_acc_fifo #(.W(DATA_WIDTH + ID_WIDTH), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_data({dot_result, w_head.id}),
    .i_pop(w_pop),
    .o_data({out_data, out_id}),
    .o_count(w_cnt)
  );
endmodule

// File: tb/tb_dot8_acc_sched.sv
// tb_dot8_acc_sched: scoreboard bench with a behavioural 12-stage dot8 pipeline
module tb_dot8_acc_sched;
  localparam int DW = 32, VL = 8, L = 12, IW = 8, VW = DW * VL;
  localparam logic [31:0] ONE = 32'h3f80_0000, TWO = 32'h4000_0000;
  localparam logic [31:0] F16 = 32'h4180_0000, F24 = 32'h41c0_0000, F32 = 32'h4200_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, in_first, in_last;
  logic [IW-1:0] in_id;
  logic [VW-1:0] in_a, in_b, dot_a, dot_b;
  logic [3:0] slot_id;
  logic slot_cont, dot_ena, out_valid, out_ready, busy, err;
  logic [DW-1:0] dot_acc, dot_result, out_data;
  logic [IW-1:0] out_id;
  logic [DW-1:0] pipe [L];
  logic [IW+DW-1:0] sb [$];
  logic [IW+DW-1:0] sb_exp;
  int checks = 0, errors = 0, cyc = 0;
  int t, t2, c, n, tmp;

  dot8_acc_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_id(in_id), .in_a(in_a), .in_b(in_b),
    .slot_id(slot_id), .slot_cont(slot_cont), .dot_ena(dot_ena), .dot_a(dot_a),
    .dot_b(dot_b), .dot_acc(dot_acc), .dot_result(dot_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] f);
    real m;
    int e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int e;
    real m;
    if (r == 0.0) return 32'h0;
    s = r < 0.0;
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] dotf(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [31:0] acc);
    real s;
    s = f2r(acc);
    for (int i = 0; i < VL; i++) s = s + f2r(a[i*32 +: 32]) * f2r(b[i*32 +: 32]);
    return r2f(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dot_ena ? dotf(dot_a, dot_b, dot_acc) : '0;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dot_result = pipe[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_extra", 64'(out_id), 64'hffff);
      else begin
        sb_exp = sb.pop_front();
        chk("sb_out", 64'({out_id, out_data}), 64'(sb_exp));
      end
    end
  end

  task automatic send(input logic f, input logic l, input logic [IW-1:0] id,
                      input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] expv, output int ta);
    bit ok;
    ok = 1'b0;
    ta = -1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      in_first = f; in_last = l; in_id = id;
      in_a = {VL{av}}; in_b = {VL{bv}};
      in_valid = (f != slot_cont);
      #4;
      if (in_valid && in_ready) begin ok = 1'b1; ta = cyc; end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    else if (l) sb.push_back({id, expv});
  endtask

  task automatic wait_out(output int co);
    co = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #2;
      if (out_valid) begin co = cyc; break; end
    end
    if (co < 0) chk("out_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_first = 0; in_last = 0; in_id = '0; in_a = '0; in_b = '0;
    out_ready = 1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_dot_ena", 64'(dot_ena), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_slot_cont", 64'(slot_cont), 0);
    chk("rst_busy", 64'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 chk("ena_first", 64'(dot_ena), 1);
    chk("slot_hold", 64'(slot_id), 0);
    @(posedge clk);
    #1 chk("slot_inc", 64'(slot_id), 1);

    send(1, 1, 8'd5, ONE, TWO, F16, t);
    wait_out(c);
    chk("t1_latency", 64'(c - t), 13);
    repeat (3) @(negedge clk);
    chk("t1_sb_empty", 64'(sb.size()), 0);
    chk("t1_idle", 64'(busy), 0);

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (slot_id == 4'd11) break;
    end
    send(1, 0, 8'd7, ONE, ONE, 32'h0, t);
    send(0, 0, 8'd7, ONE, ONE, 32'h0, tmp);
    send(0, 1, 8'd7, ONE, ONE, F24, t2);
    chk("t2_gap", 64'(t2 - t), 24);
    wait_out(c);
    chk("t2_latency", 64'(c - t), 37);

    for (int i = 0; i < 12; i++) send(1, 0, 8'(i), ONE, ONE, 32'h0, tmp);
    for (int i = 0; i < 12; i++) send(0, 1, 8'(i), ONE, ONE, F16, tmp);
    wait_out(c);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (!out_valid) break;
      n++;
    end
    chk("t3_run", 64'(n), 12);
    repeat (3) @(negedge clk);
    chk("t3_sb_empty", 64'(sb.size()), 0);

    send(1, 0, 8'd9, ONE, ONE, 32'h0, t);
    while (cyc < t + 12) @(negedge clk);
    chk("t4_cont1", 64'(slot_cont), 1);
    while (cyc < t + 24) @(negedge clk);
    chk("t4_cont2", 64'(slot_cont), 1);
    send(0, 1, 8'd9, ONE, ONE, F16, t2);
    chk("t4_gap", 64'(t2 - t), 36);
    wait_out(c);
    chk("t4_latency", 64'(c - t), 49);
    repeat (3) @(negedge clk);

    out_ready = 0;
    for (int i = 0; i < 16; i++) send(1, 1, 8'(20 + i), ONE, TWO, F16, tmp);
    @(negedge clk);
    in_first = 1; in_last = 1; in_id = 8'd36; in_a = {VL{ONE}}; in_b = {VL{TWO}};
    in_valid = 1;
    #4 chk("t5_block", 64'(in_ready), 0);
    repeat (20) @(negedge clk);
    #4 chk("t5_block_late", 64'(in_ready), 0);
    chk("t5_fifo_valid", 64'(out_valid), 1);
    @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    #4 chk("t5_accept", 64'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 0;
    sb.push_back({8'd36, F16});
    @(negedge clk);
    out_ready = 1;
    repeat (40) @(negedge clk);
    chk("t5_sb_empty", 64'(sb.size()), 0);
    chk("t5_no_err", 64'(err), 0);

    send(1, 0, 8'd40, ONE, ONE, 32'h0, t);
    while (cyc < t + 12) @(negedge clk);
    in_first = 1; in_last = 1; in_id = 8'd41; in_valid = 1;
    #4 chk("t6_reject", 64'(in_ready), 0);
    @(posedge clk);
    #1 in_valid = 0;
    chk("t6_err", 64'(err), 1);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", 64'(err), 1);
    chk("t6_busy", 64'(busy), 1);
    @(negedge clk);
    rst = 1;
    #1 chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_err", 64'(err), 0);
    chk("t6_rst_out_valid", 64'(out_valid), 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    send(1, 1, 8'd3, TWO, TWO, F32, t);
    wait_out(c);
    chk("t6_recover_latency", 64'(c - t), 13);
    repeat (3) @(negedge clk);
    chk("t6_sb_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
